// File: rtl/divisor_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package divisor_pkg;

  localparam int DIV_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divisor_sequencial_if.sv
// Request/result bundle for divisor_sequencial: master issues operands, slave returns q/r.
interface divisor_sequencial_if
  import divisor_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         div_zero;

  modport master (
    output start, a, b,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, a, b,
    output q, r, busy, done, div_zero
  );

endinterface

// File: rtl/divisor_sequencial_subtrator.sv
// W-bit trial subtractor: d = x - y, borrow set when y > x.
module subtrator #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] d,
  output logic         borrow
);

  assign {borrow, d} = {1'b0, x} - {1'b0, y};

endmodule

// File: rtl/divisor_sequencial.sv
// Multi-cycle unsigned restoring divider, one trial subtract per clock.
// Optional: define DIVISOR_EARLY_EXIT_EN to finish b==0 and a<b requests without CALC cycles.
module divisor_sequencial
  import divisor_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  divisor_sequencial_if.slave   bus
);

  localparam int CW = $clog2(N + 1);

  div_state_t    state;
  logic [CW-1:0] count;
  logic [N:0]    rem;
  logic [N-1:0]  quo;
  logic [N-1:0]  dvs;

  logic [N:0]    rem_sh;
  logic [N:0]    trial;
  logic          borrow;
  logic [N:0]    rem_step;
  logic [N-1:0]  quo_step;
  logic          early;

  // The shifted partial remainder always fits N+1 bits because it stays below 2*B.
  subtrator #(.W(N + 1)) u_sub (
    .x      (rem_sh),
    .y      ({1'b0, dvs}),
    .d      (trial),
    .borrow (borrow)
  );

  always_comb begin
    rem_sh   = {rem[N-1:0], quo[N-1]};
    quo_step = {quo[N-2:0], ~borrow};
    rem_step = borrow ? rem_sh : trial;
`ifdef DIVISOR_EARLY_EXIT_EN
    early    = (bus.b == '0) || (bus.a < bus.b);
`else
    early    = 1'b0;
`endif
  end

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      bus.q        <= '0;
      bus.r        <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dvs          <= bus.b;
            quo          <= bus.a;
            rem          <= '0;
            count        <= CW'(N);
            bus.div_zero <= (bus.b == '0);
            if (early) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.q    <= (bus.b == '0) ? '1 : '0;
              bus.r    <= bus.a;
            end else begin
              state    <= CALC;
              bus.busy <= 1'b1;
              bus.done <= 1'b0;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
          end
        end

        CALC: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.q    <= quo_step;
            bus.r    <= rem_step[N-1:0];
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: directed latency/handshake steps plus a
// scoreboard of expected quotient/remainder popped at every done pulse.
module tb_divisor_sequencial;
  import divisor_pkg::*;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  divisor_sequencial_if #(.N(N)) bus ();

  divisor_sequencial #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard side: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      check("sb_has_entry_at_done", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("q", 32'(bus.q), 32'(e.q));
        check("r", 32'(bus.r), 32'(e.r));
        check("div_zero", 32'(bus.div_zero), 32'(e.dz));
      end
    end
  end

  // Counts negedges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.busy === 1'b1) busy_cnt++;
    end while (bus.done !== 1'b1 && cyc < 30);
    if (bus.done !== 1'b1) check("done_timeout", 32'(bus.done), 1);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int cyc, output int busy_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(cyc, busy_cnt);
  endtask

  initial begin
    int cyc, bcnt, lat_exp, busy_exp;
    int done_seen, first_done, second_done;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(negedge clk);
    check("reset_q", 32'(bus.q), 0);
    check("reset_r", 32'(bus.r), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_div_zero", 32'(bus.div_zero), 0);
    rst = 1'b0;

    run_op(8'd100, 8'd7, cyc, bcnt);
    check("lat_100_7", 32'(cyc), 9);
    check("busy_100_7", 32'(bcnt), 8);

    run_op(8'd255, 8'd1, cyc, bcnt);
    run_op(8'd0, 8'd5, cyc, bcnt);

`ifdef DIVISOR_EARLY_EXIT_EN
    lat_exp  = 1;
    busy_exp = 0;
`else
    lat_exp  = 9;
    busy_exp = 8;
`endif
    run_op(8'd200, 8'd0, cyc, bcnt);
    check("lat_200_0", 32'(cyc), 32'(lat_exp));
    check("busy_200_0", 32'(bcnt), 32'(busy_exp));

    run_op(8'd9, 8'd10, cyc, bcnt);
    check("lat_9_10", 32'(cyc), 32'(lat_exp));

    run_op(8'd37, 8'd37, cyc, bcnt);

    // Back-to-back with start held; operands changed mid-CALC must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd50;
    bus.b     = 8'd5;
    sb.push_back(model(8'd50, 8'd5));
    @(posedge clk);
    done_seen   = 0;
    first_done  = 0;
    second_done = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.a = 8'd1;
        bus.b = 8'd1;
      end
      if (i == 2) begin
        bus.a = 8'd63;
        bus.b = 8'd8;
        sb.push_back(model(8'd63, 8'd8));
      end
      if (i == 10) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_seen++;
        if (done_seen == 1) first_done = i;
        if (done_seen == 2) second_done = i;
      end
    end
    check("b2b_done_count", 32'(done_seen), 2);
    check("b2b_first_lat", 32'(first_done), 9);
    check("b2b_spacing", 32'(second_done - first_done), 9);

    // Asynchronous reset three cycles into CALC aborts the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd77;
    bus.b     = 8'd3;
    sb.push_back(model(8'd77, 8'd3));
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_q", 32'(bus.q), 0);
    check("abort_r", 32'(bus.r), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 0);

    run_op(8'd77, 8'd3, cyc, bcnt);
    check("after_abort_q_direct", 32'(bus.q), 25);
    check("after_abort_r_direct", 32'(bus.r), 2);

    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), cyc, bcnt);
    end

    repeat (3) @(negedge clk);
    check("sb_empty_at_end", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
